// File: rtl/mcmc_pkg.sv
// Shared encodings for the MCMC solver loop: scheduler states, the
// top-module state handed to the search unit, and variable type codes.
package mcmc_pkg;

    typedef enum logic [7:0] {
        S_IDLE        = 8'd0,
        S_FETCH_TYPE  = 8'd1,
        S_LAUNCH      = 8'd2,
        S_WAIT_SEARCH = 8'd3,
        S_DECIDE      = 8'd4,
        S_COMMIT      = 8'd5,
        S_REJECT      = 8'd6,
        S_ADVANCE     = 8'd7,
        S_FINISHED    = 8'd8
    } sched_state_e;

    localparam logic [7:0] TOP_STATE_NONE          = 8'd0;
    localparam logic [7:0] TOP_STATE_PROBABALISTIC = 8'd1;

    typedef enum logic [1:0] {
        VT_BOOLEAN  = 2'b00,
        VT_CONT_INT = 2'b01,
        VT_DISC_INT = 2'b10,
        VT_INVALID  = 2'b11
    } var_type_e;

    function automatic logic is_invalid_type(input logic [1:0] var_type);
        return var_type == VT_INVALID;
    endfunction

endpackage

// File: rtl/metropolis_accept.sv
// Metropolis accept/reject: registers (U < P) or (P == 1.0) when the
// search result is captured, so the verdict is ready in the following cycle.
module metropolis_accept #(
    parameter int PROB_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_capture,
    input  logic [PROB_WIDTH-1:0] i_probability,
    input  logic [PROB_WIDTH-1:0] i_random_u,
    output logic                  o_accept
);

    logic r_accept;
    logic w_accept_now;

    // P of all-ones represents 1.0, which U can equal but must still accept.
    assign w_accept_now = (i_random_u < i_probability) || (&i_probability);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_accept <= 1'b0;
        end else if (i_capture) begin
            r_accept <= w_accept_now;
        end
    end

    assign o_accept = r_accept;

endmodule

// File: rtl/mcmc_iteration_scheduler.sv
// Iteration sequencer for the MCMC solver: round-robin variable pick, search
// launch, timeout supervision, Metropolis decision and commit/reject strobes.
module mcmc_iteration_scheduler
    import mcmc_pkg::*;
#(
    parameter int VAR_INDEX_WIDTH = 4,
    parameter int ITER_WIDTH      = 16,
    parameter int PROB_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       in_clk,
    input  logic                       in_reset_n,
    input  logic                       in_start,
    input  logic [ITER_WIDTH-1:0]      in_max_iterations,
    input  logic [VAR_INDEX_WIDTH-1:0] in_last_variable_index,
    input  logic [1:0]                 in_variable_type,
    input  logic                       in_search_done,
    input  logic [PROB_WIDTH-1:0]      in_acceptance_probability,
    input  logic [PROB_WIDTH-1:0]      in_random_u,
    input  logic                       in_all_clauses_satisfied,
    output logic [7:0]                 out_top_module_state,
    output logic [VAR_INDEX_WIDTH-1:0] out_variable_index,
    output logic [1:0]                 out_choosen_variable_type,
    output logic                       out_commit_enable,
    output logic                       out_reject_enable,
    output logic [ITER_WIDTH-1:0]      out_iteration_count,
    output logic                       out_busy,
    output logic                       out_done,
    output logic                       out_solution_found,
    output logic                       out_timeout_error,
    output logic [7:0]                 out_scheduler_state
);

    localparam int                     TO_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0]        TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]        TO_ONE    = TO_W'(1);
    localparam logic [ITER_WIDTH-1:0]  ITER_ONE  = ITER_WIDTH'(1);
    localparam logic [VAR_INDEX_WIDTH-1:0] IDX_ONE = VAR_INDEX_WIDTH'(1);

    sched_state_e                r_state;
    sched_state_e                w_state_next;
    logic [1:0]                  r_rst_sync;
    logic [ITER_WIDTH-1:0]       r_limit;
    logic [VAR_INDEX_WIDTH-1:0]  r_last_index;
    logic [ITER_WIDTH-1:0]       r_count;
    logic [VAR_INDEX_WIDTH-1:0]  r_index;
    logic [1:0]                  r_type;
    logic                        r_solution_found;
    logic                        r_timeout_error;
    logic [TO_W-1:0]             r_timeout_cnt;

    logic                        w_run_ok;
    logic                        w_start_accepted;
    logic                        w_timeout_hit;
    logic                        w_capture;
    logic                        w_accept;
    logic [ITER_WIDTH-1:0]       w_count_inc;
    logic [VAR_INDEX_WIDTH-1:0]  w_index_next;

    // Deassertion of the async reset is brought into the clock domain first;
    // the FSM stays in IDLE until the second stage has seen it.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run_ok     = r_rst_sync[1];
    assign w_count_inc  = r_count + ITER_ONE;
    assign w_index_next = (r_index == r_last_index) ? '0 : (r_index + IDX_ONE);
    assign w_capture    = (r_state == S_WAIT_SEARCH) && in_search_done;

    metropolis_accept #(
        .PROB_WIDTH (PROB_WIDTH)
    ) u_accept (
        .i_clk         (in_clk),
        .i_reset_n     (in_reset_n),
        .i_capture     (w_capture),
        .i_probability (in_acceptance_probability),
        .i_random_u    (in_random_u),
        .o_accept      (w_accept)
    );

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_start_accepted = 1'b0;
        w_timeout_hit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_start && w_run_ok) begin
                    w_start_accepted = 1'b1;
                    w_state_next = (in_max_iterations == '0) ? S_FINISHED : S_FETCH_TYPE;
                end
            end
            S_FETCH_TYPE: begin
                w_state_next = is_invalid_type(in_variable_type) ? S_REJECT : S_LAUNCH;
            end
            S_LAUNCH: begin
                w_state_next = S_WAIT_SEARCH;
            end
            S_WAIT_SEARCH: begin
                // A done pulse in the final allowed cycle still counts as on time.
                if (in_search_done) begin
                    w_state_next = S_DECIDE;
                end else if (r_timeout_cnt == TO_LAST) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_FINISHED;
                end
            end
            S_DECIDE: begin
                w_state_next = w_accept ? S_COMMIT : S_REJECT;
            end
            S_COMMIT, S_REJECT: begin
                w_state_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (in_all_clauses_satisfied || (w_count_inc == r_limit)) begin
                    w_state_next = S_FINISHED;
                end else begin
                    w_state_next = S_FETCH_TYPE;
                end
            end
            S_FINISHED: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_limit          <= '0;
            r_last_index     <= '0;
            r_count          <= '0;
            r_index          <= '0;
            r_type           <= '0;
            r_solution_found <= 1'b0;
            r_timeout_error  <= 1'b0;
            r_timeout_cnt    <= '0;
        end else begin
            if (w_start_accepted) begin
                r_limit          <= in_max_iterations;
                r_last_index     <= in_last_variable_index;
                r_count          <= '0;
                r_index          <= '0;
                r_solution_found <= 1'b0;
                r_timeout_error  <= 1'b0;
            end
            if (r_state == S_FETCH_TYPE) begin
                r_type <= in_variable_type;
            end
            if (r_state == S_LAUNCH) begin
                r_timeout_cnt <= '0;
            end else if (r_state == S_WAIT_SEARCH) begin
                r_timeout_cnt <= r_timeout_cnt + TO_ONE;
            end
            if (w_timeout_hit) begin
                r_timeout_error <= 1'b1;
            end
            if (r_state == S_ADVANCE) begin
                r_count <= w_count_inc;
                r_index <= w_index_next;
                if (in_all_clauses_satisfied) begin
                    r_solution_found <= 1'b1;
                end
            end
        end
    end

    assign out_top_module_state      = (r_state == S_LAUNCH) ? TOP_STATE_PROBABALISTIC
                                                             : TOP_STATE_NONE;
    assign out_variable_index        = r_index;
    assign out_choosen_variable_type = r_type;
    assign out_commit_enable         = (r_state == S_COMMIT);
    assign out_reject_enable         = (r_state == S_REJECT);
    assign out_iteration_count       = r_count;
    assign out_busy                  = (r_state != S_IDLE) && (r_state != S_FINISHED);
    assign out_done                  = (r_state == S_FINISHED);
    assign out_solution_found        = r_solution_found;
    assign out_timeout_error         = r_timeout_error;
    assign out_scheduler_state       = r_state;

endmodule

// File: tb/tb_mcmc_iteration_scheduler.sv
// Bench for mcmc_iteration_scheduler: table of runs with a commit/reject
// scoreboard, plus hand-written timeout, zero-limit and mid-run reset cases.
module tb_mcmc_iteration_scheduler;

    logic        in_clk = 1'b0;
    logic        in_reset_n = 1'b1;
    logic        in_start = 1'b0;
    logic [15:0] in_max_iterations = '0;
    logic [3:0]  in_last_variable_index = '0;
    logic [1:0]  in_variable_type;
    logic        in_search_done;
    logic [15:0] in_acceptance_probability;
    logic [15:0] in_random_u;
    logic        in_all_clauses_satisfied;
    logic [7:0]  out_top_module_state;
    logic [3:0]  out_variable_index;
    logic [1:0]  out_choosen_variable_type;
    logic        out_commit_enable;
    logic        out_reject_enable;
    logic [15:0] out_iteration_count;
    logic        out_busy;
    logic        out_done;
    logic        out_solution_found;
    logic        out_timeout_error;
    logic [7:0]  out_scheduler_state;

    logic [1:0]  tb_types [16];
    logic [15:0] tb_p = '0;
    logic [15:0] tb_u = '0;
    logic        tb_sat_en = 1'b0;
    logic [15:0] tb_sat_at = '0;
    logic        done_model = 1'b0;
    logic        spur_done = 1'b0;
    logic        search_en = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int n_commit = 0;
    int n_reject = 0;
    int n_launch = 0;
    int n_wait = 0;

    typedef struct {
        logic [15:0] limit;
        logic [3:0]  last;
        logic [7:0]  types;
        logic [15:0] p;
        logic [15:0] u;
        bit          sat_en;
        logic [15:0] sat_at;
        bit          accept;
        int          exp_count;
        int          exp_commits;
        int          exp_launch;
        bit          exp_sol;
    } vec_t;

    typedef struct {
        int idx;
        bit commit;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[10];

    assign in_variable_type          = tb_types[out_variable_index];
    assign in_search_done            = done_model | spur_done;
    assign in_acceptance_probability = tb_p;
    assign in_random_u               = tb_u;
    assign in_all_clauses_satisfied  = tb_sat_en && (out_iteration_count == tb_sat_at);

    always #5 in_clk = ~in_clk;

    mcmc_iteration_scheduler #(
        .VAR_INDEX_WIDTH (4),
        .ITER_WIDTH      (16),
        .PROB_WIDTH      (16),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .in_clk                    (in_clk),
        .in_reset_n                (in_reset_n),
        .in_start                  (in_start),
        .in_max_iterations         (in_max_iterations),
        .in_last_variable_index    (in_last_variable_index),
        .in_variable_type          (in_variable_type),
        .in_search_done            (in_search_done),
        .in_acceptance_probability (in_acceptance_probability),
        .in_random_u               (in_random_u),
        .in_all_clauses_satisfied  (in_all_clauses_satisfied),
        .out_top_module_state      (out_top_module_state),
        .out_variable_index        (out_variable_index),
        .out_choosen_variable_type (out_choosen_variable_type),
        .out_commit_enable         (out_commit_enable),
        .out_reject_enable         (out_reject_enable),
        .out_iteration_count       (out_iteration_count),
        .out_busy                  (out_busy),
        .out_done                  (out_done),
        .out_solution_found        (out_solution_found),
        .out_timeout_error         (out_timeout_error),
        .out_scheduler_state       (out_scheduler_state)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Search unit model: done pulse five cycles into WAIT_SEARCH.
    initial begin
        forever begin
            @(negedge in_clk);
            if (out_top_module_state == 8'd1 && search_en) begin
                repeat (5) @(negedge in_clk);
                done_model = 1'b1;
                @(negedge in_clk);
                done_model = 1'b0;
            end
        end
    end

    // Output monitor and scoreboard consumer.
    initial begin
        sb_t e;
        forever begin
            @(negedge in_clk);
            if (out_top_module_state == 8'd1) begin
                n_launch++;
                chk("launch_type", out_choosen_variable_type, tb_types[out_variable_index]);
            end
            if (out_scheduler_state == 8'd3) n_wait++;
            if (out_commit_enable) n_commit++;
            if (out_reject_enable) n_reject++;
            if (out_commit_enable || out_reject_enable) begin
                if (sb_q.size() == 0) begin
                    chk("sb_pending_on_pulse", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_index", out_variable_index, e.idx);
                    chk("sb_commit", out_commit_enable, e.commit);
                    chk("sb_reject", out_reject_enable, !e.commit);
                    chk("sb_type", out_choosen_variable_type, tb_types[e.idx]);
                    $display("txn idx=%0d commit=%0d reject=%0d count=%0d",
                             out_variable_index, out_commit_enable, out_reject_enable,
                             out_iteration_count);
                end
            end
        end
    end

    task automatic set_types(input logic [7:0] types);
        for (int k = 0; k < 16; k++) begin
            tb_types[k] = (k < 4) ? types[2*k +: 2] : 2'b01;
        end
    endtask

    task automatic clear_counters();
        n_commit = 0;
        n_reject = 0;
        n_launch = 0;
        n_wait   = 0;
    endtask

    // Start pulse, then re-drive limit/last index, a spurious done and a
    // second start while busy; none of these may disturb the run.
    task automatic start_run(input logic [15:0] lim, input logic [3:0] last);
        @(negedge in_clk);
        in_max_iterations      = lim;
        in_last_variable_index = last;
        in_start               = 1'b1;
        @(negedge in_clk);
        in_start               = 1'b0;
        in_max_iterations      = 16'd7;
        in_last_variable_index = 4'd15;
        spur_done              = 1'b1;
        @(negedge in_clk);
        spur_done              = 1'b0;
        in_start               = 1'b1;
        @(negedge in_clk);
        in_start               = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int c = 0; c < 4000; c++) begin
            if (out_done) break;
            @(negedge in_clk);
        end
        chk({name, "_done_seen"}, out_done, 1);
    endtask

    task automatic check_all_zero(input string p);
        chk({p, "_top_state"}, out_top_module_state, 0);
        chk({p, "_index"}, out_variable_index, 0);
        chk({p, "_type"}, out_choosen_variable_type, 0);
        chk({p, "_commit"}, out_commit_enable, 0);
        chk({p, "_reject"}, out_reject_enable, 0);
        chk({p, "_count"}, out_iteration_count, 0);
        chk({p, "_busy"}, out_busy, 0);
        chk({p, "_done"}, out_done, 0);
        chk({p, "_solution"}, out_solution_found, 0);
        chk({p, "_timeout"}, out_timeout_error, 0);
        chk({p, "_sched_state"}, out_scheduler_state, 0);
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        string nm;
        sb_t   e;
        nm = $sformatf("v%0d", vi);
        set_types(v.types);
        tb_p      = v.p;
        tb_u      = v.u;
        tb_sat_en = v.sat_en;
        tb_sat_at = v.sat_at;
        clear_counters();
        for (int i = 0; i < v.exp_count; i++) begin
            e.idx    = i % (int'(v.last) + 1);
            e.commit = v.accept && (tb_types[e.idx] != 2'b11);
            sb_q.push_back(e);
        end
        start_run(v.limit, v.last);
        wait_done(nm);
        chk({nm, "_count"}, out_iteration_count, v.exp_count);
        chk({nm, "_solution"}, out_solution_found, v.exp_sol);
        chk({nm, "_timeout"}, out_timeout_error, 0);
        chk({nm, "_busy"}, out_busy, 0);
        chk({nm, "_commits"}, n_commit, v.exp_commits);
        chk({nm, "_rejects"}, n_reject, v.exp_count - v.exp_commits);
        chk({nm, "_launches"}, n_launch, v.exp_launch);
        chk({nm, "_sb_left"}, sb_q.size(), 0);
        $display("run %s count=%0d commits=%0d launches=%0d solution=%0d",
                 nm, out_iteration_count, n_commit, n_launch, out_solution_found);
        @(negedge in_clk);
        chk({nm, "_idle_after"}, out_scheduler_state, 0);
        sb_q.delete();
    endtask

    initial begin
        bit got;
        //              limit  last  types  P         U         sat   sat_at accept cnt com lau sol
        vecs[0] = '{16'd3,  4'd1,  8'h55, 16'h8000, 16'h4000, 1'b0, 16'd0, 1'b1, 3,  3,  3,  1'b0};
        vecs[1] = '{16'd2,  4'd1,  8'h55, 16'h1000, 16'h2000, 1'b0, 16'd0, 1'b0, 2,  0,  2,  1'b0};
        vecs[2] = '{16'd2,  4'd1,  8'h55, 16'hFFFF, 16'hFFFF, 1'b0, 16'd0, 1'b1, 2,  2,  2,  1'b0};
        vecs[3] = '{16'd2,  4'd1,  8'h5D, 16'h8000, 16'h4000, 1'b0, 16'd0, 1'b1, 2,  1,  1,  1'b0};
        vecs[4] = '{16'd10, 4'd1,  8'h55, 16'h8000, 16'h4000, 1'b1, 16'd0, 1'b1, 1,  1,  1,  1'b1};
        vecs[5] = '{16'd3,  4'd1,  8'h55, 16'h8000, 16'h4000, 1'b1, 16'd2, 1'b1, 3,  3,  3,  1'b1};
        vecs[6] = '{16'd1,  4'd0,  8'h55, 16'h0000, 16'h0000, 1'b0, 16'd0, 1'b0, 1,  0,  1,  1'b0};
        vecs[7] = '{16'd5,  4'd2,  8'h61, 16'h8000, 16'h7FFF, 1'b0, 16'd0, 1'b1, 5,  5,  5,  1'b0};
        vecs[8] = '{16'd2,  4'd3,  8'h55, 16'h8000, 16'h8000, 1'b0, 16'd0, 1'b0, 2,  0,  2,  1'b0};
        vecs[9] = '{16'd17, 4'd15, 8'h55, 16'hFFFF, 16'h0000, 1'b0, 16'd0, 1'b1, 17, 17, 17, 1'b0};
        set_types(8'h55);

        // Reset state
        #1 in_reset_n = 1'b0;
        repeat (2) @(negedge in_clk);
        check_all_zero("reset");
        in_reset_n = 1'b1;
        repeat (4) @(negedge in_clk);

        // Search never finishes: timeout after exactly 64 WAIT_SEARCH cycles
        search_en = 1'b0;
        set_types(8'h55);
        clear_counters();
        start_run(16'd3, 4'd1);
        wait_done("tmo");
        chk("tmo_wait_cycles", n_wait, 64);
        chk("tmo_error", out_timeout_error, 1);
        chk("tmo_count", out_iteration_count, 0);
        chk("tmo_commits", n_commit + n_reject, 0);
        chk("tmo_launches", n_launch, 1);
        $display("run tmo wait_cycles=%0d timeout=%0d", n_wait, out_timeout_error);
        search_en = 1'b1;
        repeat (2) @(negedge in_clk);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Zero iteration limit: done within 2 cycles, nothing launched
        clear_counters();
        @(negedge in_clk);
        in_max_iterations = 16'd0;
        in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            if (out_done) begin
                got = 1'b1;
                break;
            end
            @(negedge in_clk);
        end
        chk("max0_done_within_2", got, 1);
        chk("max0_launches", n_launch, 0);
        chk("max0_count", out_iteration_count, 0);
        $display("run max0 done=%0d launches=%0d", got, n_launch);
        repeat (3) @(negedge in_clk);

        // Async reset while waiting on the search unit
        set_types(8'h55);
        tb_sat_en = 1'b0;
        clear_counters();
        start_run(16'd3, 4'd1);
        for (int c = 0; c < 100; c++) begin
            if (out_scheduler_state == 8'd3) break;
            @(negedge in_clk);
        end
        chk("midrst_in_wait", out_scheduler_state, 3);
        #2 in_reset_n = 1'b0;
        #1 check_all_zero("midrst");
        repeat (8) @(negedge in_clk);
        chk("midrst_no_commit", n_commit, 0);
        in_reset_n = 1'b1;
        repeat (5) @(negedge in_clk);
        chk("midrst_idle_after", out_scheduler_state, 0);
        sb_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
